// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl: buffers N words, bubble-sorts them with one shared comparator, streams them out ascending
module cmp_sort_ctrl #(
  parameter int W = 3,
  parameter int N = 4,
  localparam int SCW = $clog2(N*(N-1)/2+1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic           busy,
  output logic [SCW-1:0] swap_count
);
  localparam int IW = $clog2(N);
  localparam int MAXS = N*(N-1)/2;
  localparam logic [IW-1:0] LAST = IW'(N-1);
  localparam logic [IW-1:0] PMAX = IW'(N-2);
  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;
  state_t state, state_nx;
  logic [W-1:0] bank [N];
  logic [IW-1:0] wr_idx, rd_idx, p, j, j1, r1;
  logic [W-1:0] a, b;
  logic flag, gt, pass_end, sort_done, in_fire, out_fire;
  assign j1 = j + IW'(1);
  assign r1 = rd_idx + IW'(1);
  assign a = bank[j];
  assign b = bank[j1];
  assign gt = a > b;
  assign pass_end = j == PMAX - p;
  // a pass that swapped nothing (including this cycle's compare) means the block is sorted
  assign sort_done = pass_end && (!(flag || gt) || p == PMAX);
  assign in_fire = state == LOAD && in_valid;
  assign out_fire = state == DRAIN && out_ready;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= LOAD;
    else state <= state_nx;
  // next state and status outputs
  always_comb begin
    state_nx = state;
    if (in_fire && wr_idx == LAST) state_nx = SORT;
    if (state == SORT && sort_done) state_nx = DRAIN;
    if (out_fire && rd_idx == LAST) state_nx = LOAD;
    in_ready = state == LOAD;
    busy = state != LOAD;
    out_last = state == DRAIN && rd_idx == LAST;
  end
  // buffer, compare-and-swap datapath and registered output word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) bank[i] <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
      p <= '0;
      j <= '0;
      flag <= 1'b0;
      swap_count <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      if (in_fire) begin
        bank[wr_idx] <= in_data;
        wr_idx <= wr_idx == LAST ? '0 : wr_idx + IW'(1);
        if (wr_idx == LAST) begin
          swap_count <= '0;
          p <= '0;
          j <= '0;
          flag <= 1'b0;
        end
      end
      if (state == SORT) begin
        if (gt) begin
          bank[j] <= b;
          bank[j1] <= a;
          flag <= 1'b1;
          swap_count <= swap_count == SCW'(MAXS) ? swap_count : swap_count + SCW'(1);
        end
        if (sort_done) begin
          out_valid <= 1'b1;
          out_data <= (j == '0 && gt) ? b : bank[0];
        end else if (pass_end) begin
          p <= p + IW'(1);
          j <= '0;
          flag <= 1'b0;
        end else j <= j1;
      end
      if (out_fire) begin
        if (rd_idx == LAST) begin
          out_valid <= 1'b0;
          rd_idx <= '0;
          wr_idx <= '0;
        end else begin
          rd_idx <= r1;
          out_data <= bank[r1];
        end
      end
    end
endmodule
